// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, geometry and address slicing helpers for the
// direct-mapped write-back data cache controller.
package dcache_pkg;

  localparam int ADDR_W    = 30;
  localparam int TAG_W     = 22;
  localparam int IDX_W     = 5;
  localparam int OFF_W     = 3;
  localparam int BLK_W     = 256;
  localparam int MADDR_W   = TAG_W + IDX_W;
  localparam int NUM_LINES = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_REFILL    = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [MADDR_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU load/store port plus 256-bit block memory port.
//
// Handshake semantics: the CPU raises proc_read/proc_write and holds them,
// with address/data stable, until a cycle where proc_stall=0; that cycle is
// the completion cycle (proc_rdata valid for loads). The controller raises
// mem_read/mem_write and holds mem_addr/mem_wdata stable until it samples
// mem_ready=1 on a rising clock edge; mem_rdata is valid while mem_ready=1.
interface dcache_if
  import dcache_pkg::*;
();

  logic               proc_read;
  logic               proc_write;
  logic [ADDR_W-1:0]  proc_addr;
  logic [31:0]        proc_wdata;
  logic               proc_stall;
  logic [31:0]        proc_rdata;

  logic               mem_read;
  logic               mem_write;
  logic [MADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]   mem_wdata;
  logic [BLK_W-1:0]   mem_rdata;
  logic               mem_ready;

  // Controller side.
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_stall, proc_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // CPU and memory side.
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_stall, proc_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: per-line tag/valid/dirty state. Combinational read of
// the addressed line, synchronous write, asynchronous clear on reset.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             set_dirty,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty
);

  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // Refill installs a clean valid line; a write hit only marks it dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      tag_q[idx]   <= fill_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back cache controller in front of a
// 32x256-bit data-array macro. Hit/miss detection, dirty-victim write-back
// and block refill over a 256-bit memory handshake.
// Optional: define DCACHE_STATS_EN to enable saturating hit/miss counters;
// otherwise hit_cnt/miss_cnt are tied to zero.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dcache_if.slave          bus,
  output logic [IDX_W-1:0] da_A,
  output logic [BLK_W-1:0] da_D,
  output logic             da_WEN,
  input  logic [BLK_W-1:0] da_Q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output state_e           dbg_state
);

  state_e           state;
  logic [BLK_W-1:0] victim_q;
  logic [BLK_W-1:0] refill_q;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] line_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req_act;
  logic             line_valid;
  logic             line_dirty;
  logic             hit;
  logic             fill;
  logic             set_dirty;

  assign req_tag   = addr_tag(bus.proc_addr);
  assign req_idx   = addr_idx(bus.proc_addr);
  assign req_off   = addr_off(bus.proc_addr);
  assign req_act   = bus.proc_read | bus.proc_write;
  assign hit       = line_valid && (line_tag == req_tag);
  assign fill      = (state == S_REFILL);
  assign set_dirty = (state == S_COMPARE) && hit && bus.proc_write;
  assign da_A      = req_idx;
  assign dbg_state = state;

  dcache_tag_array u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (req_idx),
    .fill     (fill),
    .fill_tag (req_tag),
    .set_dirty(set_dirty),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty)
  );

  // Controller FSM; victim and refill blocks are captured on the way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      victim_q <= '0;
      refill_q <= '0;
    end else begin
      case (state)
        S_IDLE:      if (req_act) state <= S_COMPARE;
        S_COMPARE: begin
          if (hit || !req_act) begin
            state <= S_IDLE;
          end else if (line_valid && line_dirty) begin
            victim_q <= da_Q;
            state    <= S_WRITEBACK;
          end else begin
            state <= S_ALLOCATE;
          end
        end
        // Memory transactions run to completion even if the request drops.
        S_WRITEBACK: if (bus.mem_ready) state <= S_ALLOCATE;
        S_ALLOCATE: begin
          if (bus.mem_ready) begin
            refill_q <= bus.mem_rdata;
            state    <= S_REFILL;
          end
        end
        S_REFILL:    state <= S_COMPARE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Per-state drive of the CPU, memory and data-array ports.
  always_comb begin
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    da_D           = '0;
    da_WEN         = 1'b1;
    case (state)
      S_IDLE:    bus.proc_stall = req_act;
      S_COMPARE: begin
        bus.proc_stall = req_act && !hit;
        if (hit && bus.proc_write) begin
          // Stores win when both strobes are raised together.
          da_WEN                       = 1'b0;
          da_D                         = da_Q;
          da_D[{req_off, 5'd0} +: 32]  = bus.proc_wdata;
        end else if (hit && bus.proc_read) begin
          bus.proc_rdata = da_Q[{req_off, 5'd0} +: 32];
        end
      end
      S_WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {line_tag, req_idx};
        bus.mem_wdata  = victim_q;
      end
      S_ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = addr_blk(bus.proc_addr);
      end
      S_REFILL: begin
        bus.proc_stall = 1'b1;
        da_WEN         = 1'b0;
        da_D           = refill_q;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // High between REFILL and the following COMPARE so that re-check is not counted.
  logic refill_seen;

  // Saturating statistics, counted on the first COMPARE of each request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      refill_seen <= 1'b0;
    end else begin
      if (state == S_REFILL)       refill_seen <= 1'b1;
      else if (state == S_COMPARE) refill_seen <= 1'b0;
      if (state == S_COMPARE && !refill_seen && req_act) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: bench for dcache_ctrl with a data-array model, a memory
// responder with programmable latency and a flat word-level reference model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst_n;
  logic [IDX_W-1:0]    da_A;
  logic [BLK_W-1:0]    da_D;
  logic                da_WEN;
  logic [BLK_W-1:0]    da_Q;
  logic [TB_CNT_W-1:0] hit_cnt;
  logic [TB_CNT_W-1:0] miss_cnt;
  state_e              dbg_state;

  dcache_if bus ();

  dcache_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .da_A(da_A), .da_D(da_D), .da_WEN(da_WEN), .da_Q(da_Q),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data-array macro model ----------------
  logic [BLK_W-1:0] da_mem [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_Q <= '0;
      for (int i = 0; i < 32; i++) da_mem[i] <= '0;
    end else if (!da_WEN) begin
      da_mem[da_A] <= da_D;
      da_Q         <= da_D;
    end else begin
      da_Q <= da_mem[da_A];
    end
  end

  // ---------------- backing memory + responder ----------------
  logic [BLK_W-1:0]   bmem [logic [MADDR_W-1:0]];
  logic [MADDR_W-1:0] rd_q[$];
  logic [MADDR_W-1:0] wb_q[$];
  logic [BLK_W-1:0]   wbd_q[$];
  int                 mem_delay;
  int                 wcnt;

  function automatic logic [31:0] init_word(int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [BLK_W-1:0] init_blk(int unsigned b);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = init_word(b * 8 + i);
    return r;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      wcnt          = 0;
    end else begin
      bus.mem_ready = 1'b0;
      if (bus.mem_read || bus.mem_write) begin
        if (wcnt >= mem_delay) begin
          wcnt          = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_write) begin
            bmem[bus.mem_addr] = bus.mem_wdata;
            wb_q.push_back(bus.mem_addr);
            wbd_q.push_back(bus.mem_wdata);
          end else begin
            if (!bmem.exists(bus.mem_addr)) bmem[bus.mem_addr] = init_blk(int'(bus.mem_addr));
            bus.mem_rdata = bmem[bus.mem_addr];
            rd_q.push_back(bus.mem_addr);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0]  ref_words [int unsigned];
  bit           ref_valid [32];
  bit           ref_dirty [32];
  int unsigned  ref_tag   [32];
  int unsigned  ref_hits, ref_misses;
  logic [31:0]  exp_q[$];
  int           exp_cycles;
  bit           exp_rd, exp_wb;
  logic [MADDR_W-1:0] exp_rd_addr, exp_wb_addr;
  logic [BLK_W-1:0]   exp_wb_data;

  function automatic logic [31:0] word_of(int unsigned a);
    return ref_words.exists(a) ? ref_words[a] : init_word(a);
  endfunction

  function automatic logic [TB_CNT_W-1:0] exp_cnt(int unsigned n);
`ifdef DCACHE_STATS_EN
    return (n >= (1 << TB_CNT_W)) ? '1 : TB_CNT_W'(n);
`else
    return (n == 0) ? '0 : '0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = 0;
    end
    ref_hits = 0; ref_misses = 0;
  endtask

  // One CPU access as the CPU sees it: latest store wins, lines map by index.
  task automatic model_access(input bit wr, input int unsigned addr, input logic [31:0] wd, input int d);
    int unsigned blk, idx, tag;
    logic [BLK_W-1:0] b;
    blk = addr / 8; idx = blk % 32; tag = addr / 256;
    exp_rd = 0; exp_wb = 0;
    if (ref_valid[idx] && ref_tag[idx] == tag) begin
      ref_hits++;
      exp_cycles = 2;
    end else begin
      ref_misses++;
      exp_rd = 1; exp_rd_addr = MADDR_W'(blk);
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_wb = 1;
        exp_wb_addr = MADDR_W'(ref_tag[idx] * 32 + idx);
        for (int i = 0; i < 8; i++) b[32*i +: 32] = word_of((ref_tag[idx] * 32 + idx) * 8 + i);
        exp_wb_data = b;
        exp_cycles = 6 + 2 * d;
      end else begin
        exp_cycles = 5 + d;
      end
      ref_valid[idx] = 1; ref_tag[idx] = tag; ref_dirty[idx] = 0;
    end
    if (wr) begin
      ref_words[addr] = wd;
      ref_dirty[idx]  = 1;
    end else begin
      exp_q.push_back(word_of(addr));
    end
  endtask

  // ---------------- driver ----------------
  int          n_cmp, n_fail;
  logic [31:0] obs_rdata;
  int          obs_cycles, obs_rd_cycles, obs_wr_cycles, obs_unstable;
  int          rd_base, wb_base;

  task automatic cpu_access(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wd);
    bit done, pv_rd, pv_wr;
    logic [MADDR_W-1:0] pv_addr;
    logic [BLK_W-1:0]   pv_wd;
    @(negedge clk);
    bus.proc_read = rd; bus.proc_write = wr; bus.proc_addr = addr; bus.proc_wdata = wd;
    rd_base = rd_q.size(); wb_base = wb_q.size();
    obs_cycles = 0; obs_rd_cycles = 0; obs_wr_cycles = 0; obs_unstable = 0;
    obs_rdata = 'x; done = 0; pv_rd = 0; pv_wr = 0; pv_addr = '0; pv_wd = '0;
    while (!done && obs_cycles < 400) begin
      #1;
      obs_cycles++;
      if (bus.mem_read)  obs_rd_cycles++;
      if (bus.mem_write) obs_wr_cycles++;
      if ((bus.mem_read || bus.mem_write) && !bus.proc_stall) obs_unstable++;
      if (((pv_rd && bus.mem_read) || (pv_wr && bus.mem_write)) &&
          (pv_addr !== bus.mem_addr || pv_wd !== bus.mem_wdata)) obs_unstable++;
      pv_rd = bus.mem_read; pv_wr = bus.mem_write; pv_addr = bus.mem_addr; pv_wd = bus.mem_wdata;
      if (!bus.proc_stall) begin
        obs_rdata = bus.proc_rdata;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    bus.proc_read = 0; bus.proc_write = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0) begin n_fail++;
      $display("FAIL reset_proc: stall=%b rdata=%h want 0/0", bus.proc_stall, bus.proc_rdata); end
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin n_fail++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h want all zero", bus.mem_read, bus.mem_write, bus.mem_addr); end
    n_cmp++; if (da_A !== 5'd0 || da_D !== '0 || da_WEN !== 1'b1) begin n_fail++;
      $display("FAIL reset_da: A=%h WEN=%b want 0/1", da_A, da_WEN); end
    n_cmp++; if (hit_cnt !== '0 || miss_cnt !== '0 || dbg_state !== S_IDLE) begin n_fail++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d state=%0d want 0/0/IDLE", hit_cnt, miss_cnt, dbg_state); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cold_read();
    logic [BLK_W-1:0] b;
    b = init_blk(2); b[31:0] = 32'hDEADBEEF;
    bmem[27'h2] = b; ref_words[32'h10] = 32'hDEADBEEF;
    mem_delay = 0;
    model_access(0, 32'h10, 0, 0);
    cpu_access(1, 0, 30'h10, 0);
    n_cmp++; if (rd_q.size() - rd_base != 1 || rd_q[rd_base] !== 27'h2) begin n_fail++;
      $display("FAIL cold_read_mem: reads=%0d addr=%h want 1/0000002", rd_q.size() - rd_base, rd_q[rd_base]); end
    n_cmp++; if (obs_rdata !== exp_q[0] || exp_q[0] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL cold_read_data: got %h want deadbeef", obs_rdata); end
    void'(exp_q.pop_front());
    n_cmp++; if (obs_cycles != exp_cycles) begin n_fail++;
      $display("FAIL cold_read_lat: got %0d want %0d", obs_cycles, exp_cycles); end
    n_cmp++; if (miss_cnt !== exp_cnt(ref_misses)) begin n_fail++;
      $display("FAIL cold_read_miss_cnt: got %0d want %0d", miss_cnt, exp_cnt(ref_misses)); end
  endtask

  task automatic test_read_hit();
    model_access(0, 32'h10, 0, mem_delay);
    cpu_access(1, 0, 30'h10, 0);
    n_cmp++; if (obs_cycles != 2 || rd_q.size() != rd_base || wb_q.size() != wb_base) begin n_fail++;
      $display("FAIL read_hit_lat: cycles=%0d mem_ops=%0d want 2/0", obs_cycles, rd_q.size() - rd_base + wb_q.size() - wb_base); end
    n_cmp++; if (obs_rdata !== exp_q.pop_front()) begin n_fail++;
      $display("FAIL read_hit_data: got %h", obs_rdata); end
    n_cmp++; if (hit_cnt !== exp_cnt(ref_hits)) begin n_fail++;
      $display("FAIL read_hit_cnt: got %0d want %0d", hit_cnt, exp_cnt(ref_hits)); end
  endtask

  task automatic test_write_hit();
    model_access(1, 32'h13, 32'h12345678, mem_delay);
    cpu_access(0, 1, 30'h13, 32'h12345678);
    n_cmp++; if (obs_cycles != 2 || rd_q.size() != rd_base) begin n_fail++;
      $display("FAIL write_hit_lat: got %0d want 2", obs_cycles); end
    model_access(0, 32'h13, 0, mem_delay);
    cpu_access(1, 0, 30'h13, 0);
    n_cmp++; if (obs_rdata !== 32'h12345678 || exp_q.pop_front() !== 32'h12345678) begin n_fail++;
      $display("FAIL write_hit_readback: got %h want 12345678", obs_rdata); end
  endtask

  task automatic test_dirty_evict();
    model_access(0, 32'h113, 0, mem_delay);
    cpu_access(1, 0, 30'h113, 0);
    n_cmp++; if (wb_q.size() - wb_base != 1 || wb_q[wb_base] !== 27'h2 || wbd_q[wb_base][127:96] !== 32'h12345678) begin n_fail++;
      $display("FAIL evict_wb: n=%0d addr=%h word3=%h want 1/0000002/12345678", wb_q.size() - wb_base, wb_q[wb_base], wbd_q[wb_base][127:96]); end
    n_cmp++; if (wbd_q[wb_base] !== exp_wb_data) begin n_fail++;
      $display("FAIL evict_wb_block: got %h want %h", wbd_q[wb_base], exp_wb_data); end
    n_cmp++; if (rd_q.size() - rd_base != 1 || rd_q[rd_base] !== 27'h22) begin n_fail++;
      $display("FAIL evict_refill: addr=%h want 0000022", rd_q[rd_base]); end
    n_cmp++; if (obs_rdata !== exp_q.pop_front() || obs_cycles != exp_cycles) begin n_fail++;
      $display("FAIL evict_read: data=%h cycles=%0d want cycles %0d", obs_rdata, obs_cycles, exp_cycles); end
  endtask

  task automatic test_rw_both();
    model_access(1, 32'h11, 32'hCAFEF00D, mem_delay);
    cpu_access(1, 1, 30'h11, 32'hCAFEF00D);
    model_access(0, 32'h11, 0, mem_delay);
    cpu_access(1, 0, 30'h11, 0);
    n_cmp++; if (obs_rdata !== exp_q.pop_front()) begin n_fail++;
      $display("FAIL rw_both: got %h want cafef00d", obs_rdata); end
  endtask

  task automatic test_mem_delay();
    mem_delay = 5;
    model_access(0, 32'h2000, 0, 5);
    cpu_access(1, 0, 30'h2000, 0);
    n_cmp++; if (obs_rd_cycles != 6 || obs_unstable != 0 || obs_cycles != exp_cycles) begin n_fail++;
      $display("FAIL delay_read: rd_cycles=%0d unstable=%0d cycles=%0d want 6/0/%0d", obs_rd_cycles, obs_unstable, obs_cycles, exp_cycles); end
    n_cmp++; if (obs_rdata !== exp_q.pop_front()) begin n_fail++;
      $display("FAIL delay_read_data: got %h", obs_rdata); end
    mem_delay = 3;
    model_access(1, 32'h2001, 32'hA5A51234, 3);
    cpu_access(0, 1, 30'h2001, 32'hA5A51234);
    model_access(0, 32'h2101, 0, 3);
    cpu_access(1, 0, 30'h2101, 0);
    n_cmp++; if (obs_wr_cycles != 4 || obs_rd_cycles != 4 || obs_unstable != 0 || obs_cycles != exp_cycles) begin n_fail++;
      $display("FAIL delay_evict: wr=%0d rd=%0d unstable=%0d cycles=%0d want 4/4/0/%0d", obs_wr_cycles, obs_rd_cycles, obs_unstable, obs_cycles, exp_cycles); end
    n_cmp++; if (wb_q.size() - wb_base != 1 || wb_q[wb_base] !== exp_wb_addr || wbd_q[wb_base] !== exp_wb_data) begin n_fail++;
      $display("FAIL delay_evict_wb: addr=%h want %h", wb_q[wb_base], exp_wb_addr); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    int unsigned tag, idx, off, sel, addr;
    logic [31:0] wd, ev;
    bit wr;
    for (int n = 0; n < 60; n++) begin
      tag = $urandom_range(0, 3); idx = $urandom_range(0, 3); off = $urandom_range(0, 7);
      addr = tag * 256 + idx * 8 + off;
      sel = $urandom_range(0, 3); wr = (sel >= 2); wd = $urandom;
      mem_delay = $urandom_range(0, 3);
      model_access(wr, addr, wd, mem_delay);
      cpu_access(sel != 2, wr, 30'(addr), wd);
      n_cmp++; if (obs_cycles != exp_cycles) begin n_fail++;
        $display("FAIL rand_lat[%0d]: addr=%h got %0d want %0d", n, addr, obs_cycles, exp_cycles); end
      n_cmp++; if ((rd_q.size() - rd_base) != int'(exp_rd) || (exp_rd && rd_q[rd_base] !== exp_rd_addr)) begin n_fail++;
        $display("FAIL rand_refill[%0d]: n=%0d want %0d addr %h", n, rd_q.size() - rd_base, exp_rd, exp_rd_addr); end
      n_cmp++; if ((wb_q.size() - wb_base) != int'(exp_wb) ||
                   (exp_wb && (wb_q[wb_base] !== exp_wb_addr || wbd_q[wb_base] !== exp_wb_data))) begin n_fail++;
        $display("FAIL rand_wb[%0d]: n=%0d want %0d addr %h", n, wb_q.size() - wb_base, exp_wb, exp_wb_addr); end
      if (!wr) begin
        ev = exp_q.pop_front();
        n_cmp++; if (obs_rdata !== ev) begin n_fail++;
          $display("FAIL rand_data[%0d]: addr=%h got %h want %h", n, addr, obs_rdata, ev); end
      end
      n_cmp++; if (hit_cnt !== exp_cnt(ref_hits) || miss_cnt !== exp_cnt(ref_misses)) begin n_fail++;
        $display("FAIL rand_cnt[%0d]: hit=%0d miss=%0d want %0d/%0d", n, hit_cnt, miss_cnt, exp_cnt(ref_hits), exp_cnt(ref_misses)); end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    mem_delay = 20;
    @(negedge clk);
    bus.proc_read = 1; bus.proc_write = 0; bus.proc_addr = 30'h3F000;
    guard = 0;
    while (!bus.mem_read && guard < 100) begin @(negedge clk); guard++; end
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 27'h7E00) begin n_fail++;
      $display("FAIL reset_mid_alloc: mem_read=%b addr=%h want 1/0007e00", bus.mem_read, bus.mem_addr); end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== '0 || dbg_state !== S_IDLE) begin n_fail++;
      $display("FAIL reset_mid_drop: mem_read=%b addr=%h state=%0d want 0/0/IDLE", bus.mem_read, bus.mem_addr, dbg_state); end
    bus.proc_read = 0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    mem_delay = 1;
    model_access(0, 32'h3F000, 0, 1);
    cpu_access(1, 0, 30'h3F000, 0);
    n_cmp++; if (rd_q.size() - rd_base != 1 || rd_q[rd_base] !== 27'h7E00 || wb_q.size() != wb_base) begin n_fail++;
      $display("FAIL reset_mid_remiss: reads=%0d writes=%0d want 1/0", rd_q.size() - rd_base, wb_q.size() - wb_base); end
    n_cmp++; if (obs_rdata !== exp_q.pop_front() || obs_cycles != exp_cycles) begin n_fail++;
      $display("FAIL reset_mid_read: data=%h cycles=%0d want cycles %0d", obs_rdata, obs_cycles, exp_cycles); end
    n_cmp++; if (miss_cnt !== exp_cnt(1) || hit_cnt !== '0) begin n_fail++;
      $display("FAIL reset_mid_cnt: hit=%0d miss=%0d want 0/%0d", hit_cnt, miss_cnt, exp_cnt(1)); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0; n_fail = 0; mem_delay = 0;
    rst_n = 1'b0;
    bus.proc_read = 0; bus.proc_write = 0; bus.proc_addr = '0; bus.proc_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_rw_both();
    test_mem_delay();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped write-back cache controller placed between the CPU load/store port and the 32x256-bit data-array macro, D_Cache.
- Holds tag/valid/dirty state internally and drives the data array's A/D/WEN/Q port.
- Handles hit/miss detection, dirty-victim write-back, and block refill over a 256-bit memory handshake.

Parameters:
- CNT_W, 16, width of the saturating hit/miss statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- proc_read  in  1  CPU load request, held until proc_stall=0
- proc_write  in  1  CPU store request, held until proc_stall=0
- proc_addr  in  30  word address: tag[29:8], index[7:3], word offset[2:0]
- proc_wdata  in  32  store data
- proc_stall  out  1  request in flight and not completing this cycle
- proc_rdata  out  32  load data, valid when request active and proc_stall=0
- mem_read  out  1  block read request
- mem_write  out  1  block write request
- mem_addr  out  27  block address {tag,index}
- mem_wdata  out  256  victim block
- mem_rdata  in  256  refill block, valid while mem_ready=1
- mem_ready  in  1  memory completion strobe
- da_A  out  5  data-array index
- da_D  out  256  data-array write data
- da_WEN  out  1  data-array write enable, active-low
- da_Q  in  256  data-array registered read data (1-cycle latency; Q<=D on write)
- hit_cnt  out  CNT_W  hit counter
- miss_cnt  out  CNT_W  miss counter

Behaviour:
- Reset state:
  - State IDLE; tag/valid/dirty all cleared.
  - proc_stall=0, proc_rdata=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - da_A=0, da_D=0, da_WEN=1.
  - Counters 0.
- Index driving: da_A is combinational from proc_addr[7:3] in every state. da_WEN=1 except in the write cases below.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL.
- IDLE:
  - proc_read or proc_write → COMPARE; proc_stall=1 this cycle.
  - proc_read and proc_write together: treated as a write.
- COMPARE:
  - da_Q holds the indexed block. hit = valid[idx] && tag[idx]==proc_addr[29:8].
  - Read hit: proc_rdata = da_Q[32*off +: 32]; proc_stall=0; → IDLE.
  - Write hit: da_WEN=0; da_D = da_Q with word off replaced by proc_wdata; dirty[idx]=1; proc_stall=0; → IDLE.
  - Miss with valid && dirty: capture da_Q into the victim register; → WRITEBACK.
  - Miss otherwise: → ALLOCATE.
  - Stats increment only on the first COMPARE of a request; the post-refill COMPARE is not counted.
- WRITEBACK:
  - mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=victim.
  - All held stable until mem_ready=1 is sampled; → ALLOCATE. mem_write=0 the next cycle.
- ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[29:3].
  - On mem_ready=1: capture mem_rdata; → REFILL.
- REFILL:
  - da_WEN=0, da_D=refill block.
  - tag[idx]=proc_addr tag, valid=1, dirty=0; → COMPARE.
  - The array returns the refill block on da_Q next cycle, so COMPARE hits and completes the request normally.
- proc_stall=1 in every non-completing cycle while a request is active; proc_stall=0 when idle.
- Latency:
  - Hit: 2 cycles.
  - Clean miss: 4 cycles plus memory wait.
  - Dirty miss: additional write-back cycles plus memory wait.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-operation: immediate return to IDLE, memory request dropped, all lines invalid. The data array is reset by the same rst_n.
- Request withdrawn before completion: not legal. Behaviour is undefined, but the controller must still finish any memory transaction it has started.

Optional Feature:
- DCACHE_STATS_EN defined: hit_cnt/miss_cnt count first-COMPARE hits/misses, saturating at all-ones.
- Not defined: both ports tied to 0 and the counter logic is absent.

Decomposition:
- Package dcache_pkg: state enum; TAG_W=22, IDX_W=5, OFF_W=3, BLK_W=256 localparams; address field slicing functions.
- Sub-module dcache_tag_array: 32 entries of tag+valid+dirty, async reset clear, combinational read, synchronous write (tag/valid/dirty written together on refill; dirty-only write on write hit).

Test Plan:
- Cold read at addr 0x0000010 after reset → miss, mem_read with mem_addr=0x0000002; return block with word0=0xDEADBEEF → proc_rdata=0xDEADBEEF, miss_cnt=1.
- Repeat read at 0x0000010 → hit in 2 cycles, no mem traffic, hit_cnt=1.
- Write 0x12345678 to 0x0000013, then read 0x0000013 → both hits; read returns 0x12345678; line dirty.
- Read 0x0000113 (same index 2, tag 1) → mem_write at mem_addr=0x0000002 with word3=0x12345678, then mem_read at mem_addr=0x0000022.
- mem_ready delayed 5 cycles → mem_read/mem_addr stable throughout, proc_stall=1 throughout.
- Assert rst_n low during ALLOCATE → mem_read=0 immediately; a subsequent read of the same address misses.
